n2by2_b2_seq_integer_recombiner: RTL

- Sequential signed recombiner in base 2, two's complement. Computes x = q*y + r from a quotient, divisor and remainder.
- It is the inverse direction of the team's integer divider: it rebuilds the dividend.
- It also flags operand triples that no valid truncated division could have produced.
- Used as the checker/reconstructor stage after the divider, with an soc/eoc handshake.

---
 rtl/n2by2_b2_seq_integer_recombiner_pkg.sv | 18 +
 rtl/n2by2_b2_seq_integer_recombiner_ms_converter.sv | 16 +
 rtl/n2by2_b2_seq_integer_recombiner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/n2by2_b2_seq_integer_recombiner_pkg.sv
// Shared types and constants for the sequential signed recombiner x = q*y + r.
package n2by2_b2_seq_integer_recombiner_pkg;

  localparam int unsigned DEFAULT_N = 2;
  localparam int unsigned STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Step counter width: clog2(n), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/n2by2_b2_seq_integer_recombiner_ms_converter.sv
// Combinational two's-complement to magnitude/sign converter; the most negative
// code maps to its unsigned magnitude 2^(N-1).
module nN_c2_ms_converter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] mag,
  output logic         sign
);

  always_comb begin
    sign = a[N-1];
    mag  = sign ? (N'(0) - a) : a;
  end

endmodule

// File: rtl/n2by2_b2_seq_integer_recombiner.sv
// Sequential recombiner: rebuilds the dividend x = q*y + r with a shift-and-add
// multiplier and flags triples no truncated division could have produced.
module n2by2_b2_seq_integer_recombiner
  import n2by2_b2_seq_integer_recombiner_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           soc,
  input  logic [N-1:0]   q,
  input  logic [N-1:0]   y,
  input  logic [N-1:0]   r,
  output logic [2*N-1:0] x,
  output logic           no_idiv,
  output logic           eoc
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = cnt_width(N);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    mplr_q;
  logic [W2-1:0]   mcand_q;
  logic [W2-1:0]   acc_q;
  logic [N-1:0]    r_q;
  logic            q_sign_q;
  logic            y_sign_q;
  logic            r_sign_q;
  logic            y_zero_q;
  logic            r_ge_y_q;

  logic            start_c;
  logic            step_c;
  logic            fix_c;
  logic            last_c;

  logic [N-1:0]    q_mag_c;
  logic [N-1:0]    y_mag_c;
  logic [N-1:0]    r_mag_c;
  logic            q_sign_c;
  logic            y_sign_c;
  logic            r_sign_c;

  logic [W2-1:0]   prod_c;
  logic [W2-1:0]   sum_c;
  logic            flag_c;

  nN_c2_ms_converter #(.N(N)) u_conv_q (.a(q), .mag(q_mag_c), .sign(q_sign_c));
  nN_c2_ms_converter #(.N(N)) u_conv_y (.a(y), .mag(y_mag_c), .sign(y_sign_c));
  nN_c2_ms_converter #(.N(N)) u_conv_r (.a(r), .mag(r_mag_c), .sign(r_sign_c));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (soc) state_d = S_MUL;
      S_MUL:   if (last_c) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    start_c = 1'b0;
    step_c  = 1'b0;
    fix_c   = 1'b0;
    case (state_q)
      S_IDLE:  start_c = soc;
      S_MUL:   step_c  = 1'b1;
      S_FIX:   fix_c   = 1'b1;
      default: ;
    endcase
  end

  assign last_c = (cnt_q == CW'(N - 1));

  // Sign fix of the unsigned product, then remainder add and consistency check
  always_comb begin
    prod_c = (q_sign_q ^ y_sign_q) ? (W2'(0) - acc_q) : acc_q;
    sum_c  = prod_c + {{N{r_sign_q}}, r_q};
    flag_c = y_zero_q | r_ge_y_q | ((r_q != '0) & (sum_c[W2-1] != r_sign_q));
  end

  // Operand capture and shift-and-add multiplier
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      mplr_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      q_sign_q <= 1'b0;
      y_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      y_zero_q <= 1'b0;
      r_ge_y_q <= 1'b0;
    end else if (start_c) begin
      cnt_q    <= '0;
      mplr_q   <= q_mag_c;
      mcand_q  <= {{N{1'b0}}, y_mag_c};
      acc_q    <= '0;
      r_q      <= r;
      q_sign_q <= q_sign_c;
      y_sign_q <= y_sign_c;
      r_sign_q <= r_sign_c;
      y_zero_q <= (y == '0);
      r_ge_y_q <= (r_mag_c >= y_mag_c);
    end else if (step_c) begin
      if (mplr_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mplr_q  <= mplr_q >> 1;
      mcand_q <= mcand_q << 1;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Registered outputs: eoc drops on start, result and eoc land on the fix edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x       <= '0;
      no_idiv <= 1'b0;
      eoc     <= 1'b1;
    end else if (start_c) begin
      eoc <= 1'b0;
    end else if (fix_c) begin
      x       <= sum_c;
      no_idiv <= flag_c;
      eoc     <= 1'b1;
    end
  end

endmodule
